sysid_checker: RTL and testbench

Boot-time and periodic identity checker that sits directly upstream of the system-ID slave. It acts as a minimal read master: it drives the slave's one-bit address, samples its 32-bit readdata for the ID word (address 0) and the timestamp word (address 1), and compares both against build-time expected values. It then raises match/mismatch status for the rest of the design, such as an LED driver or reset sequencer, so a bitstream/software mismatch is flagged before the quadrature-decoder logic is trusted.

---
 rtl/sysid_checker_if.sv | 10 +
 rtl/sysid_checker.sv | 133 +++++++++++++
 tb/tb_sysid_checker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_if.sv
// Read path between the identity checker and the system-ID slave.
// The checker drives a one-bit word address. The slave returns that word
// combinationally on readdata.
interface sysid_checker_if;
    logic        sysid_address;
    logic [31:0] sysid_readdata;

    modport master (output sysid_address, input  sysid_readdata);
    modport slave  (input  sysid_address, output sysid_readdata);
endinterface

// File: rtl/sysid_checker.sv
// Boot-time and periodic identity checker for the system-ID slave.
// The checker reads the ID word (address 0) and then the timestamp word
// (address 1). It compares both words with the expected build values and
// publishes sticky match/mismatch status.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | address 0; waits for start, a pending auto-start or a recheck
// RD_ID | address 0; holds for READ_WAIT cycles, then captures the ID word
// RD_TS | address 1; holds for READ_WAIT cycles, then captures the timestamp
// DONE  | address 0; one-cycle done pulse, new status flags are visible
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd102,
    parameter logic [31:0] EXPECTED_TS    = 32'd1526569095,
    parameter int unsigned READ_WAIT      = 1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned RECHECK_PERIOD = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    sysid_checker_if.master sysid,
    output logic            busy,
    output logic            done,
    output logic            checked,
    output logic            id_ok,
    output logic            ts_ok,
    output logic            match,
    output logic [31:0]     id_value,
    output logic [31:0]     ts_value,
    output logic [7:0]      mismatch_count
);
    localparam logic [3:0]  WAIT_LAST    = 4'(READ_WAIT - 1);
    localparam bit          RECHECK_EN   = (RECHECK_PERIOD != 0);
    localparam logic [23:0] RECHECK_LAST = RECHECK_EN ? 24'(RECHECK_PERIOD - 1) : 24'd0;

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        wait_last;
    logic        auto_pend;
    logic [23:0] recheck_cnt;
    logic        recheck_fire;
    logic        launch;
    logic        id_match;
    logic        ts_match;

    assign wait_last    = (wait_cnt == WAIT_LAST);
    assign recheck_fire = RECHECK_EN && checked && (recheck_cnt == RECHECK_LAST);
    assign launch       = start || auto_pend || recheck_fire;
    // The ID word is already captured when the timestamp arrives.
    // The timestamp is compared straight from the bus, on the edge that stores it.
    assign id_match     = (id_value == EXPECTED_ID);
    assign ts_match     = (sysid.sysid_readdata == EXPECTED_TS);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Next-state selection; concurrent triggers in IDLE collapse into one check.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch)    state_nxt = RD_ID;
            RD_ID:   if (wait_last) state_nxt = RD_TS;
            RD_TS:   if (wait_last) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Read-hold counter; it restarts at every read-state boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if ((state == RD_ID || state == RD_TS) && !wait_last)
            wait_cnt <= wait_cnt + 4'd1;
        else
            wait_cnt <= '0;
    end

    // Auto-start request; it stays pending until the first check is launched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                  auto_pend <= AUTO_START;
        else if (state == IDLE && state_nxt == RD_ID)  auto_pend <= 1'b0;
    end

    // Idle timer for periodic rechecks. The timer runs only after the first check has completed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            recheck_cnt <= '0;
        else if (state != IDLE || start || recheck_fire)
            recheck_cnt <= '0;
        else if (RECHECK_EN && checked)
            recheck_cnt <= recheck_cnt + 24'd1;
    end

    // The slave address is registered from the next state, so it changes only on clock edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sysid.sysid_address <= 1'b0;
        else          sysid.sysid_address <= (state_nxt == RD_TS);
    end

    // Data capture at the end of each read state; the status updates on entry to DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value       <= '0;
            ts_value       <= '0;
            id_ok          <= 1'b0;
            ts_ok          <= 1'b0;
            match          <= 1'b0;
            checked        <= 1'b0;
            mismatch_count <= '0;
        end else if (state == RD_ID && wait_last) begin
            id_value <= sysid.sysid_readdata;
        end else if (state == RD_TS && wait_last) begin
            ts_value <= sysid.sysid_readdata;
            id_ok    <= id_match;
            ts_ok    <= ts_match;
            match    <= id_match && ts_match;
            checked  <= 1'b1;
            if (!(id_match && ts_match) && mismatch_count != 8'hFF)
                mismatch_count <= mismatch_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker with three instances:
//   d=0: READ_WAIT=1, auto-start, no recheck
//   d=1: READ_WAIT=3, no auto-start
//   d=2: READ_WAIT=1, auto-start, recheck every 20 idle cycles
// Each instance has a behavioural slave. A reference model predicts
// busy/address/done from the launch offset and tracks the status flags.
module tb_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'd102;
    localparam logic [31:0] EXP_TS = 32'd1526569095;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n   [3];
    logic        start   [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        chk_o   [3];
    logic        idok_o  [3];
    logic        tsok_o  [3];
    logic        match_o [3];
    logic [31:0] idv_o   [3];
    logic [31:0] tsv_o   [3];
    logic [7:0]  mc_o    [3];
    logic        addr_w  [3];
    logic [31:0] slv_id  [3];
    logic [31:0] slv_ts  [3];
    int          exp_mc  [3];

    int checks = 0;
    int errors = 0;

    sysid_checker_if bus0 ();
    sysid_checker_if bus1 ();
    sysid_checker_if bus2 ();

    assign bus0.sysid_readdata = bus0.sysid_address ? slv_ts[0] : slv_id[0];
    assign bus1.sysid_readdata = bus1.sysid_address ? slv_ts[1] : slv_id[1];
    assign bus2.sysid_readdata = bus2.sysid_address ? slv_ts[2] : slv_id[2];
    assign addr_w[0] = bus0.sysid_address;
    assign addr_w[1] = bus1.sysid_address;
    assign addr_w[2] = bus2.sysid_address;

    sysid_checker #(.READ_WAIT(1), .AUTO_START(1'b1), .RECHECK_PERIOD(0)) u0 (
        .clock(clock), .reset_n(rst_n[0]), .start(start[0]), .sysid(bus0.master),
        .busy(busy_o[0]), .done(done_o[0]), .checked(chk_o[0]), .id_ok(idok_o[0]),
        .ts_ok(tsok_o[0]), .match(match_o[0]), .id_value(idv_o[0]), .ts_value(tsv_o[0]),
        .mismatch_count(mc_o[0]));

    sysid_checker #(.READ_WAIT(3), .AUTO_START(1'b0), .RECHECK_PERIOD(0)) u1 (
        .clock(clock), .reset_n(rst_n[1]), .start(start[1]), .sysid(bus1.master),
        .busy(busy_o[1]), .done(done_o[1]), .checked(chk_o[1]), .id_ok(idok_o[1]),
        .ts_ok(tsok_o[1]), .match(match_o[1]), .id_value(idv_o[1]), .ts_value(tsv_o[1]),
        .mismatch_count(mc_o[1]));

    sysid_checker #(.READ_WAIT(1), .AUTO_START(1'b1), .RECHECK_PERIOD(20)) u2 (
        .clock(clock), .reset_n(rst_n[2]), .start(start[2]), .sysid(bus2.master),
        .busy(busy_o[2]), .done(done_o[2]), .checked(chk_o[2]), .id_ok(idok_o[2]),
        .ts_ok(tsok_o[2]), .match(match_o[2]), .id_value(idv_o[2]), .ts_value(tsv_o[2]),
        .mismatch_count(mc_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_busy",  busy_o[d],  0);
        chk("rst_done",  done_o[d],  0);
        chk("rst_chk",   chk_o[d],   0);
        chk("rst_idok",  idok_o[d],  0);
        chk("rst_tsok",  tsok_o[d],  0);
        chk("rst_match", match_o[d], 0);
        chk("rst_idv",   idv_o[d],   0);
        chk("rst_tsv",   tsv_o[d],   0);
        chk("rst_mc",    mc_o[d],    0);
        chk("rst_addr",  addr_w[d],  0);
    endtask

    function automatic logic [31:0] pick_id();
        return ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
    endfunction

    function automatic logic [31:0] pick_ts();
        return ($urandom_range(0, 3) != 0) ? EXP_TS : $urandom;
    endfunction

    // Entered #1 after an edge with the DUT idle. The next edge launches a check
    // (by start pulse, auto-start or recheck). Observation n is #1 after the
    // n-th edge from the launch edge inclusive. The task returns at the first
    // idle observation after DONE. Data outside the final read cycle is junk.
    // With junk=1, random start pulses are also issued while the DUT is busy.
    task automatic run_check(input int d, input int rw, input bit pulse, input bit junk,
                             input logic [31:0] idv, input logic [31:0] tsv);
        bit iok;
        bit tok;
        iok = (idv == EXP_ID);
        tok = (tsv == EXP_TS);
        slv_id[d] = idv;
        slv_ts[d] = tsv;
        if (pulse) start[d] = 1'b1;
        @(posedge clock); #1;
        start[d] = 1'b0;
        for (int n = 1; n <= 2*rw+2; n++) begin
            chk("busy", busy_o[d], (n <= 2*rw+1));
            chk("addr", addr_w[d], (n > rw && n <= 2*rw));
            chk("done", done_o[d], (n == 2*rw+1));
            if (n == 2*rw+1) begin
                if (!(iok && tok) && exp_mc[d] < 255) exp_mc[d]++;
                chk("id_ok",    idok_o[d],  iok);
                chk("ts_ok",    tsok_o[d],  tok);
                chk("match",    match_o[d], iok && tok);
                chk("checked",  chk_o[d],   1);
                chk("id_value", idv_o[d],   idv);
                chk("ts_value", tsv_o[d],   tsv);
                chk("mm_count", mc_o[d],    exp_mc[d]);
            end
            if (n == 2*rw+2) begin
                chk("hold_match", match_o[d], iok && tok);
                chk("hold_mc",    mc_o[d],    exp_mc[d]);
            end else begin
                slv_id[d] = (n == rw)   ? idv : $urandom;
                slv_ts[d] = (n == 2*rw) ? tsv : $urandom;
                start[d]  = (junk && n <= 2*rw+1) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(posedge clock); #1;
            end
        end
        start[d] = 1'b0;
    endtask

    // Observe idle cycles 2..20 after a check on the recheck instance.
    task automatic idle_gap(input int d, input int period);
        for (int i = 2; i <= period; i++) begin
            @(posedge clock); #1;
            chk("gap_busy", busy_o[d], 0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        for (int d = 0; d < 3; d++) begin
            rst_n[d]  = 1'b0;
            start[d]  = 1'b0;
            slv_id[d] = EXP_ID;
            slv_ts[d] = EXP_TS;
            exp_mc[d] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);

        // Power-up auto-check, then a wrong ID twice.
        rst_n[0] = 1'b1;
        run_check(0, 1, 1'b0, 1'b0, EXP_ID, EXP_TS);
        run_check(0, 1, 1'b1, 1'b0, 32'd103, EXP_TS);
        run_check(0, 1, 1'b1, 1'b0, 32'd103, EXP_TS);

        // Random contents, with random start pulses while busy.
        repeat (40) run_check(0, 1, 1'b1, 1'b1, pick_id(), pick_ts());

        // Start held for 6 cycles: exactly two checks.
        a = pick_id();
        b = pick_ts();
        slv_id[0] = a;
        slv_ts[0] = b;
        start[0]  = 1'b1;
        for (int m = 0; m <= 10; m++) begin
            @(posedge clock); #1;
            chk("held_busy", busy_o[0], (m <= 2) || (m >= 4 && m <= 6));
            chk("held_done", done_o[0], (m == 2) || (m == 6));
            chk("held_addr", addr_w[0], (m == 1) || (m == 5));
            if (m == 5) start[0] = 1'b0;
        end
        repeat (2) if (!(a == EXP_ID && b == EXP_TS) && exp_mc[0] < 255) exp_mc[0]++;
        chk("held_mc",    mc_o[0],    exp_mc[0]);
        chk("held_match", match_o[0], (a == EXP_ID && b == EXP_TS));

        // Reset during RD_TS: outputs return to reset values at once, with no done pulse.
        slv_id[0] = EXP_ID;
        slv_ts[0] = EXP_TS;
        start[0]  = 1'b1;
        @(posedge clock); #1;
        start[0] = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_addr", addr_w[0], 1);
        rst_n[0] = 1'b0;
        #1;
        chk_reset(0);
        @(posedge clock); #1;
        chk("rst_nodone", done_o[0], 0);
        exp_mc[0] = 0;
        rst_n[0]  = 1'b1;
        run_check(0, 1, 1'b0, 1'b0, EXP_ID, EXP_TS);

        // READ_WAIT=3 without auto-start.
        rst_n[1] = 1'b1;
        repeat (9) begin
            @(posedge clock); #1;
            chk("noauto_busy", busy_o[1], 0);
        end
        run_check(1, 3, 1'b1, 1'b0, EXP_ID, EXP_TS);
        repeat (8) run_check(1, 3, 1'b1, 1'b1, pick_id(), pick_ts());

        // Periodic recheck, then saturation of the mismatch counter.
        rst_n[2] = 1'b1;
        run_check(2, 1, 1'b0, 1'b0, EXP_ID, EXP_TS);
        repeat (4) begin
            idle_gap(2, 20);
            run_check(2, 1, 1'b0, 1'b1, pick_id(), pick_ts());
        end
        repeat (300) begin
            idle_gap(2, 20);
            run_check(2, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        chk("sat_mc", mc_o[2], 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
